// File: rtl/alu_pipe_if.sv
// alu_pipe_if: handshake bundle around the pipelined EX-stage ALU.
//   Request side : in_valid, in_ready, input1, input2, ALUControl
//   Response side: out_valid, out_ready, result, zero, overflow
//   master modport is the ID/EX producer and EX/MEM consumer; slave modport is the ALU.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] input1;
  logic [WIDTH-1:0] input2;
  logic [3:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid,
    output input1,
    output input2,
    output ALUControl,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  zero,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  input1,
    input  input2,
    input  ALUControl,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output zero,
    output overflow
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered, valid/ready handshaked execute-stage ALU.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : alu_pipe_if.slave
//          in_valid/in_ready/input1/input2/ALUControl  request
//          out_valid/out_ready/result/zero/overflow     registered response
// Single-cycle ops load the one-entry output register at the accept edge. MUL (when MUL_EN)
// runs a shift-add loop for WIDTH cycles with in_ready low, then loads the output register.
module alu_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          MUL_EN = 1'b1
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave bus
);

  localparam int unsigned ShW = $clog2(WIDTH);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpSll  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSltu = 4'b1000;
  localparam logic [3:0] OpSra  = 4'b1001;
  localparam logic [3:0] OpMul  = 4'b1010;
  localparam logic [3:0] OpNor  = 4'b1100;

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d;
  logic [WIDTH-1:0] mul_b_q, mul_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [ShW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0] op_a, op_b;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             is_mul;
  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH-1:0] acc_sum;

  assign op_a  = bus.input1;
  assign op_b  = bus.input2;
  assign shamt = op_b[ShW-1:0];
  assign sum   = op_a + op_b;
  assign diff  = op_a - op_b;

  // Combinational ALU for all single-cycle opcodes.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.ALUControl)
      OpAnd:  alu_res = op_a & op_b;
      OpOr:   alu_res = op_a | op_b;
      OpXor:  alu_res = op_a ^ op_b;
      OpNor:  alu_res = ~(op_a | op_b);
      OpAdd: begin
        alu_res = sum;
        alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff;
        alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OpSll:  alu_res = op_a << shamt;
      OpSrl:  alu_res = op_a >> shamt;
      OpSra:  alu_res = $unsigned($signed(op_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // With MUL_EN clear, OpMul falls through the ALU default and yields 0 in one cycle.
  assign is_mul = MUL_EN && (bus.ALUControl == OpMul);

  // One-entry output register: accept when empty or being drained this edge.
  assign in_ready = (state_q == StIdle) && (!vld_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Shift-add step: partial product for the current multiplier bit.
  assign mul_addend = mul_b_q[cnt_q] ? (mul_a_q << cnt_q) : '0;
  assign acc_sum    = acc_q + mul_addend;

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;

    // Drain first; a result loaded on the same edge overrides this below.
    if (vld_q && bus.out_ready) begin
      vld_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul) begin
            mul_a_d = op_a;
            mul_b_d = op_b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = StMul;
          end else begin
            res_d  = alu_res;
            zero_d = (alu_res == '0);
            ovf_d  = alu_ovf;
            vld_d  = 1'b1;
          end
        end
      end
      StMul: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ShW'(WIDTH - 1)) begin
          res_d   = acc_sum;
          zero_d  = (acc_sum == '0);
          ovf_d   = 1'b0;
          vld_d   = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      res_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = vld_q;
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (WIDTH=32), plus a MUL_EN=0 instance.
module tb_alu_pipe;

  logic clk;
  logic rst;

  int n_checks;
  int n_pass;

  alu_pipe_if #(.WIDTH(32)) bus ();
  alu_pipe_if #(.WIDTH(32)) bus0 ();

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  alu_pipe #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single edge (in_ready assumed high) and check the registered output.
  task automatic run_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input logic exp_ovf);
    bus.in_valid   = 1'b1;
    bus.ALUControl = op;
    bus.input1     = a;
    bus.input2     = b;
    step();
    bus.in_valid = 1'b0;
    check({name, ".valid"}, {31'b0, bus.out_valid}, 32'd1);
    check({name, ".result"}, bus.result, exp_res);
    check({name, ".zero"}, {31'b0, bus.zero}, {31'b0, (exp_res == 32'd0)});
    check({name, ".ovf"}, {31'b0, bus.overflow}, {31'b0, exp_ovf});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int stalls;
    int seen_valid;

    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    bus.in_valid    = 1'b0;
    bus.ALUControl  = 4'd0;
    bus.input1      = '0;
    bus.input2      = '0;
    bus.out_ready   = 1'b1;
    bus0.in_valid   = 1'b0;
    bus0.ALUControl = 4'd0;
    bus0.input1     = '0;
    bus0.input2     = '0;
    bus0.out_ready  = 1'b1;

    step();
    step();
    check("rst.valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst.result", bus.result, 32'd0);
    check("rst.zero", {31'b0, bus.zero}, 32'd0);
    check("rst.ovf", {31'b0, bus.overflow}, 32'd0);
    rst = 1'b0;
    step();
    check("rst.in_ready", {31'b0, bus.in_ready}, 32'd1);

    // MUL opcode on the MUL_EN=0 instance behaves as an undefined op.
    bus0.in_valid   = 1'b1;
    bus0.ALUControl = 4'b1010;
    bus0.input1     = 32'd3;
    bus0.input2     = 32'd5;
    step();
    bus0.in_valid = 1'b0;
    check("nomul.valid", {31'b0, bus0.out_valid}, 32'd1);
    check("nomul.result", bus0.result, 32'd0);
    check("nomul.zero", {31'b0, bus0.zero}, 32'd1);

    // Back-to-back single-cycle ops with out_ready held high.
    run_vec("add_ovf",   4'b0010, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b1);
    run_vec("sub_zero",  4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0);
    run_vec("sub_ovf",   4'b0110, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b1);
    run_vec("add_wrap",  4'b0010, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b0);
    run_vec("slt",       4'b0111, 32'hffffffff, 32'h00000001, 32'h00000001, 1'b0);
    run_vec("sltu",      4'b1000, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b0);
    run_vec("sra",       4'b1001, 32'h80000000, 32'h00000004, 32'hf8000000, 1'b0);
    run_vec("srl",       4'b0101, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0);
    run_vec("sll_trunc", 4'b0100, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0);
    run_vec("and",       4'b0000, 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 1'b0);
    run_vec("or",        4'b0001, 32'hf0f0f0f0, 32'hff00ff00, 32'hfff0fff0, 1'b0);
    run_vec("xor",       4'b0011, 32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0, 1'b0);
    run_vec("nor",       4'b1100, 32'hf0f0f0f0, 32'hff00ff00, 32'h000f000f, 1'b0);
    run_vec("undef",     4'b1111, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0);
    step();
    check("drain.valid", {31'b0, bus.out_valid}, 32'd0);

    // Iterative multiply: stall length and latency measured from the accept edge.
    bus.in_valid   = 1'b1;
    bus.ALUControl = 4'b1010;
    bus.input1     = 32'h0000ffff;
    bus.input2     = 32'h00010001;
    step();
    bus.in_valid = 1'b0;
    lat    = 0;
    stalls = (bus.in_ready == 1'b0) ? 1 : 0;
    for (int e = 1; e <= 40; e++) begin
      step();
      if (bus.out_valid) begin
        lat = e;
        break;
      end
      if (!bus.in_ready) stalls++;
    end
    check("mul.latency", lat, 32'd32);
    check("mul.stalls", stalls, 32'd32);
    check("mul.result", bus.result, 32'hffffffff);
    check("mul.zero", {31'b0, bus.zero}, 32'd0);
    check("mul.in_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    check("mul.drain", {31'b0, bus.out_valid}, 32'd0);

    // Backpressure: first ADD held, second waits at the input until release.
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.ALUControl = 4'b0010;
    bus.input1     = 32'd1;
    bus.input2     = 32'd2;
    step();
    bus.input1 = 32'd10;
    bus.input2 = 32'd20;
    for (int i = 0; i < 3; i++) begin
      check("bp.hold_result", bus.result, 32'd3);
      check("bp.hold_valid", {31'b0, bus.out_valid}, 32'd1);
      check("bp.in_ready", {31'b0, bus.in_ready}, 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check("bp.second", bus.result, 32'd30);
    check("bp.second_valid", {31'b0, bus.out_valid}, 32'd1);
    bus.input1 = 32'd100;
    bus.input2 = 32'd200;
    step();
    bus.in_valid = 1'b0;
    check("bp.third", bus.result, 32'd300);
    check("bp.third_valid", {31'b0, bus.out_valid}, 32'd1);
    step();
    check("bp.empty", {31'b0, bus.out_valid}, 32'd0);

    // Reset during MUL aborts it without producing a result.
    bus.in_valid   = 1'b1;
    bus.ALUControl = 4'b1010;
    bus.input1     = 32'h0000ffff;
    bus.input2     = 32'h00010001;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rmul.in_ready", {31'b0, bus.in_ready}, 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen_valid = 1;
      step();
    end
    check("rmul.no_output", seen_valid, 32'd0);
    run_vec("post_rst_add", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
